// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM device responder: command encodings as
// seen on {cs,ras,cas,we}, the per-bank state type, err bit positions and the
// width of the per-bank / refresh timers.
// ---------------------------------------------------------------------------
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_LMR       = 4'b0000,
        CMD_REFRESH   = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_TERMINATE = 4'b0110,
        CMD_NOP       = 4'b0111
    } sdram_cmd_e;

    typedef enum logic [1:0] {
        BANK_IDLE,
        BANK_ACTIVATING,
        BANK_OPEN,
        BANK_PRECHARGING
    } bank_state_e;

    localparam int unsigned ERR_ACT_BUSY = 0;  // ACTIVE to a bank that is not idle
    localparam int unsigned ERR_RW_IDLE  = 1;  // READ/WRITE to a closed bank
    localparam int unsigned ERR_TIMING   = 2;  // tRCD / tRP / tRFC violation
    localparam int unsigned ERR_REF_BUSY = 3;  // REFRESH with a bank not idle
    localparam int unsigned ERR_REFI     = 4;  // refresh interval exceeded

    localparam int unsigned TMR_W = 8;

endpackage

// File: rtl/sdram_responder_if.sv
// ---------------------------------------------------------------------------
// sdram_responder_if
// Pin-side SDRAM bus between the controller (master) and the device
// responder (slave).
//   cle, cs, ras, cas, we : clock enable and command pins
//   dqm                   : write mask
//   ba, a                 : bank and row/column address
//   dq_in                 : write data
//   dq_out, rd_valid      : registered read data and its strobe
//   err, ref_count        : sticky protocol flags, REFRESH count
// ---------------------------------------------------------------------------
interface sdram_responder_if;

    logic        cle;
    logic        cs;
    logic        ras;
    logic        cas;
    logic        we;
    logic        dqm;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [31:0] dq_in;
    logic [31:0] dq_out;
    logic        rd_valid;
    logic [4:0]  err;
    logic [15:0] ref_count;

    modport master (
        output cle, cs, ras, cas, we, dqm, ba, a, dq_in,
        input  dq_out, rd_valid, err, ref_count
    );

    modport slave (
        input  cle, cs, ras, cas, we, dqm, ba, a, dq_in,
        output dq_out, rd_valid, err, ref_count
    );

endinterface

// File: rtl/sdram_bank_fsm.sv
// ---------------------------------------------------------------------------
// sdram_bank_fsm
// One SDRAM bank: state, open-row register and a down-counter that times
// tRCD (ACTIVATING) and tRP (PRECHARGING).
//   clk, rst   : clock, synchronous active-high reset
//   i_act      : ACTIVE addressed to this bank
//   i_pre      : PRECHARGE addressed to this bank (or all banks)
//   i_row      : row address latched on an accepted ACTIVE
//   o_state    : current bank state
//   o_row      : latched row
//   o_tmr_zero : timer has expired (window satisfied at this edge)
// ---------------------------------------------------------------------------
module sdram_bank_fsm
    import sdram_pkg::*;
#(
    parameter int unsigned T_RCD = 3,
    parameter int unsigned T_RP  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_act,
    input  logic        i_pre,
    input  logic [12:0] i_row,
    output bank_state_e o_state,
    output logic [12:0] o_row,
    output logic        o_tmr_zero
);

    // Loaded with T-1 so that a command at edge k+T sees the timer at zero.
    localparam logic [TMR_W-1:0] RCD_LOAD = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);

    bank_state_e       r_state, w_state_nxt;
    logic [TMR_W-1:0]  r_tmr,   w_tmr_nxt;
    logic [12:0]       r_row,   w_row_nxt;
    logic              w_zero;

    assign w_zero = (r_tmr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BANK_IDLE;
            r_tmr   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_row_nxt   = r_row;
        case (r_state)
            BANK_IDLE: begin
                if (i_act) begin
                    w_state_nxt = BANK_ACTIVATING;
                    w_tmr_nxt   = RCD_LOAD;
                    w_row_nxt   = i_row;
                end
            end
            BANK_ACTIVATING: begin
                if (i_pre) begin
                    w_state_nxt = BANK_PRECHARGING;
                    w_tmr_nxt   = RP_LOAD;
                end else if (w_zero) begin
                    w_state_nxt = BANK_OPEN;
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            BANK_OPEN: begin
                if (i_pre) begin
                    w_state_nxt = BANK_PRECHARGING;
                    w_tmr_nxt   = RP_LOAD;
                end
            end
            BANK_PRECHARGING: begin
                // An ACTIVE arriving exactly as tRP expires is legal and
                // goes straight to ACTIVATING; an early one is ignored.
                if (w_zero) begin
                    if (i_act) begin
                        w_state_nxt = BANK_ACTIVATING;
                        w_tmr_nxt   = RCD_LOAD;
                        w_row_nxt   = i_row;
                    end else begin
                        w_state_nxt = BANK_IDLE;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            default: w_state_nxt = BANK_IDLE;
        endcase
    end

    assign o_state    = r_state;
    assign o_row      = r_row;
    assign o_tmr_zero = w_zero;

endmodule

// File: rtl/sdram_responder.sv
// ---------------------------------------------------------------------------
// sdram_responder
// Cycle-accurate SDRAM device model / protocol checker. Decodes command
// pins, tracks four banks, stores writes in an internal array and returns
// read data after the CAS latency (2 or 3).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sdram_responder_if (command pins in; dq_out,
//              rd_valid, err, ref_count out)
// ---------------------------------------------------------------------------
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_BITS   = 4,
    parameter int unsigned CL_DEFAULT = 3,
    parameter int unsigned T_RCD      = 3,
    parameter int unsigned T_RP       = 3,
    parameter int unsigned T_RFC      = 7,
    parameter int unsigned T_REFI     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    sdram_responder_if.slave  bus
);

    localparam int unsigned AW = 2 + ROW_BITS + 8;

    sdram_cmd_e        w_cmd;
    bank_state_e       w_bank_state [4];
    logic [12:0]       w_bank_row   [4];
    logic              w_bank_zero  [4];
    bank_state_e       w_sel_state;
    logic [12:0]       w_sel_row;
    logic              w_sel_zero;
    logic              w_is_rw, w_rw_ok, w_do_read, w_do_write, w_flush;
    logic              w_any_busy;
    logic [AW-1:0]     w_idx;
    logic [4:0]        w_err_set;
    logic              w_unused;

    logic [31:0]       r_mem [2**AW];
    logic [31:0]       r_rd_word;
    logic              r_a_valid, r_a_cl2, r_b_valid;
    logic [31:0]       r_b_data;
    logic              r_cl2;
    logic              r_rd_valid;
    logic [31:0]       r_dq_out;
    logic [4:0]        r_err;
    logic [15:0]       r_ref_count;
    logic [TMR_W-1:0]  r_rfc;
    logic [31:0]       r_refi;

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sdram_bank_fsm #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .i_act      (w_cmd == CMD_ACTIVE && bus.ba == 2'(g)),
            .i_pre      (w_cmd == CMD_PRECHARGE && (bus.a[10] || bus.ba == 2'(g))),
            .i_row      (bus.a),
            .o_state    (w_bank_state[g]),
            .o_row      (w_bank_row[g]),
            .o_tmr_zero (w_bank_zero[g])
        );
    end

    always_comb begin
        w_cmd = CMD_NOP;
        if (bus.cle && !bus.cs)
            w_cmd = sdram_cmd_e'({bus.cs, bus.ras, bus.cas, bus.we});

        w_sel_state = w_bank_state[bus.ba];
        w_sel_row   = w_bank_row[bus.ba];
        w_sel_zero  = w_bank_zero[bus.ba];

        w_is_rw    = (w_cmd == CMD_READ) || (w_cmd == CMD_WRITE);
        w_rw_ok    = (w_sel_state == BANK_ACTIVATING) || (w_sel_state == BANK_OPEN);
        w_do_read  = (w_cmd == CMD_READ) && w_rw_ok;
        w_do_write = (w_cmd == CMD_WRITE) && w_rw_ok && !bus.dqm;
        w_flush    = (w_cmd == CMD_TERMINATE);
        w_idx      = {bus.ba, w_sel_row[ROW_BITS-1:0], bus.a[9:2]};

        w_any_busy = 1'b0;
        for (int unsigned i = 0; i < 4; i++)
            if (w_bank_state[i] != BANK_IDLE) w_any_busy = 1'b1;

        w_err_set = '0;
        w_err_set[ERR_ACT_BUSY] = (w_cmd == CMD_ACTIVE) &&
                                  ((w_sel_state == BANK_ACTIVATING) || (w_sel_state == BANK_OPEN));
        w_err_set[ERR_RW_IDLE]  = w_is_rw && !w_rw_ok;
        w_err_set[ERR_TIMING]   = (w_is_rw && w_sel_state == BANK_ACTIVATING && !w_sel_zero) ||
                                  (w_cmd == CMD_ACTIVE && w_sel_state == BANK_PRECHARGING && !w_sel_zero) ||
                                  (w_cmd != CMD_NOP && r_rfc != '0);
        w_err_set[ERR_REF_BUSY] = (w_cmd == CMD_REFRESH) && w_any_busy;
        // Flag as the counter steps past T_REFI, i.e. when its next value exceeds it.
        w_err_set[ERR_REFI]     = (w_cmd != CMD_REFRESH) && (r_refi >= T_REFI);
    end

    assign w_unused = ^w_sel_row[12:ROW_BITS];

    // Array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (w_do_write) r_mem[w_idx] <= bus.dq_in;
        if (w_do_read)  r_rd_word    <= r_mem[w_idx];
    end

    // Read pipeline: stage A holds the word just read, tagged with the CL in
    // force at issue. CL2 entries go straight to the output from A; CL3
    // entries pass through B. An LMR occupies a command slot, so a CL2 entry
    // in A can never coincide with a CL3 entry in B.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid   <= 1'b0;
            r_a_cl2     <= 1'b0;
            r_b_valid   <= 1'b0;
            r_b_data    <= '0;
            r_rd_valid  <= 1'b0;
            r_dq_out    <= '0;
            r_cl2       <= (CL_DEFAULT == 2);
            r_err       <= '0;
            r_ref_count <= '0;
            r_rfc       <= '0;
            r_refi      <= '0;
        end else begin
            r_a_valid  <= w_do_read;
            r_a_cl2    <= r_cl2;
            r_b_valid  <= r_a_valid && !r_a_cl2 && !w_flush;
            r_b_data   <= r_rd_word;
            r_rd_valid <= 1'b0;
            if (!w_flush) begin
                if (r_a_valid && r_a_cl2) begin
                    r_rd_valid <= 1'b1;
                    r_dq_out   <= r_rd_word;
                end else if (r_b_valid) begin
                    r_rd_valid <= 1'b1;
                    r_dq_out   <= r_b_data;
                end
            end

            if (w_cmd == CMD_LMR) begin
                if (bus.a[6:4] == 3'd2)      r_cl2 <= 1'b1;
                else if (bus.a[6:4] == 3'd3) r_cl2 <= 1'b0;
            end

            if (w_cmd == CMD_REFRESH) begin
                r_rfc  <= TMR_W'(T_RFC - 1);
                r_refi <= '0;
                if (r_ref_count != 16'hFFFF) r_ref_count <= r_ref_count + 1'b1;
            end else begin
                if (r_rfc != '0)  r_rfc  <= r_rfc - 1'b1;
                if (r_refi != '1) r_refi <= r_refi + 1'b1;
            end

            r_err <= r_err | w_err_set;
        end
    end

    assign bus.dq_out    = r_dq_out;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.err       = r_err;
    assign bus.ref_count = r_ref_count;

endmodule

// File: tb/tb_sdram_responder.sv
// ---------------------------------------------------------------------------
// tb_sdram_responder
// Directed, self-checking bench for sdram_responder.
// ---------------------------------------------------------------------------
module tb_sdram_responder;
    import sdram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;

    sdram_responder_if bus ();

    sdram_responder #(
        .ROW_BITS   (4),
        .CL_DEFAULT (3),
        .T_RCD      (3),
        .T_RP       (3),
        .T_RFC      (7),
        .T_REFI     (1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic set_nop();
        bus.cle = 1'b1;
        {bus.cs, bus.ras, bus.cas, bus.we} = 4'b0111;
        bus.dqm = 1'b0;
        bus.ba = 2'd0;
        bus.a = 13'd0;
        bus.dq_in = 32'd0;
    endtask

    task automatic nop(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        set_nop();
        rst = 1'b1;
        nop(2);
        rst = 1'b0;
    endtask

    // Present one command for exactly one rising edge, then return to NOP.
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                         input logic [31:0] d, input logic m);
        {bus.cs, bus.ras, bus.cas, bus.we} = c;
        bus.ba = b;
        bus.a = addr;
        bus.dq_in = d;
        bus.dqm = m;
        @(posedge clk);
        #1;
        {bus.cs, bus.ras, bus.cas, bus.we} = 4'b0111;
        bus.dqm = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.dq_out !== 32'd0) begin errors++; $display("FAIL reset_dq_out: got %h expected 0", bus.dq_out); end
        checks++; if (bus.err !== 5'd0) begin errors++; $display("FAIL reset_err: got %b expected 00000", bus.err); end
        checks++; if (bus.ref_count !== 16'd0) begin errors++; $display("FAIL reset_ref_count: got %0d expected 0", bus.ref_count); end
    endtask

    task automatic test_basic_rw();
        do_reset();
        issue(CMD_ACTIVE, 2'd0, 13'd5, 32'd0, 1'b0);
        nop(2);
        issue(CMD_WRITE, 2'd0, 13'h040, 32'hDEADBEEF, 1'b0);
        issue(CMD_READ, 2'd0, 13'h040, 32'd0, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got %b expected 0", bus.rd_valid); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_lat2: got %b expected 0", bus.rd_valid); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.rd_valid); end
        checks++; if (bus.dq_out !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data: got %h expected deadbeef", bus.dq_out); end
        checks++; if (bus.err !== 5'd0) begin errors++; $display("FAIL basic_err: got %b expected 00000", bus.err); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_back_to_back();
        issue(CMD_WRITE, 2'd0, 13'h044, 32'h12345678, 1'b0);
        issue(CMD_READ, 2'd0, 13'h040, 32'd0, 1'b0);
        issue(CMD_READ, 2'd0, 13'h044, 32'd0, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b expected 0", bus.rd_valid); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first: got v=%b d=%h expected v=1 d=deadbeef", bus.rd_valid, bus.dq_out); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'h12345678) begin errors++; $display("FAIL b2b_second: got v=%b d=%h expected v=1 d=12345678", bus.rd_valid, bus.dq_out); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b0 || bus.dq_out !== 32'h12345678) begin errors++; $display("FAIL b2b_hold: got v=%b d=%h expected v=0 d=12345678", bus.rd_valid, bus.dq_out); end

        // CL = 2
        issue(CMD_LMR, 2'd0, 13'h020, 32'd0, 1'b0);
        issue(CMD_READ, 2'd0, 13'h040, 32'd0, 1'b0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL cl2_early: got %b expected 0", bus.rd_valid); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'hDEADBEEF) begin errors++; $display("FAIL cl2_data: got v=%b d=%h expected v=1 d=deadbeef", bus.rd_valid, bus.dq_out); end
        issue(CMD_READ, 2'd0, 13'h044, 32'd0, 1'b0);
        issue(CMD_READ, 2'd0, 13'h040, 32'd0, 1'b0);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'h12345678) begin errors++; $display("FAIL cl2_b2b_first: got v=%b d=%h expected v=1 d=12345678", bus.rd_valid, bus.dq_out); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'hDEADBEEF) begin errors++; $display("FAIL cl2_b2b_second: got v=%b d=%h expected v=1 d=deadbeef", bus.rd_valid, bus.dq_out); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL cl2_b2b_end: got %b expected 0", bus.rd_valid); end

        // LMR with CL field 5 is ignored: latency stays 2
        issue(CMD_LMR, 2'd0, 13'h050, 32'd0, 1'b0);
        issue(CMD_READ, 2'd0, 13'h044, 32'd0, 1'b0);
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'h12345678) begin errors++; $display("FAIL lmr_ignore: got v=%b d=%h expected v=1 d=12345678", bus.rd_valid, bus.dq_out); end

        // Back to CL = 3
        issue(CMD_LMR, 2'd0, 13'h030, 32'd0, 1'b0);
        issue(CMD_READ, 2'd0, 13'h040, 32'd0, 1'b0);
        nop(1);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL cl3_restore_early: got %b expected 0", bus.rd_valid); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'hDEADBEEF) begin errors++; $display("FAIL cl3_restore_data: got v=%b d=%h expected v=1 d=deadbeef", bus.rd_valid, bus.dq_out); end
        checks++; if (bus.err !== 5'd0) begin errors++; $display("FAIL b2b_err: got %b expected 00000", bus.err); end
    endtask

    task automatic test_protocol_errors();
        do_reset();
        issue(CMD_WRITE, 2'd0, 13'h040, 32'hBAD0BAD0, 1'b0);
        checks++; if (bus.err !== 5'b00010) begin errors++; $display("FAIL err_rw_idle: got %b expected 00010", bus.err); end
        issue(CMD_ACTIVE, 2'd0, 13'd5, 32'd0, 1'b0);
        issue(CMD_READ, 2'd0, 13'h040, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b00110) begin errors++; $display("FAIL err_trcd: got %b expected 00110", bus.err); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL early_read_lat: got %b expected 0", bus.rd_valid); end
        nop(1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'hDEADBEEF) begin errors++; $display("FAIL early_read_data: got v=%b d=%h expected v=1 d=deadbeef", bus.rd_valid, bus.dq_out); end
        issue(CMD_ACTIVE, 2'd0, 13'd6, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b00111) begin errors++; $display("FAIL err_act_busy: got %b expected 00111", bus.err); end
        nop(3);
        issue(CMD_READ, 2'd0, 13'h040, 32'd0, 1'b0);
        nop(2);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'hDEADBEEF) begin errors++; $display("FAIL act_ignored_row: got v=%b d=%h expected v=1 d=deadbeef", bus.rd_valid, bus.dq_out); end

        // tRCD one short
        do_reset();
        issue(CMD_ACTIVE, 2'd3, 13'd0, 32'd0, 1'b0);
        nop(1);
        issue(CMD_WRITE, 2'd3, 13'h000, 32'h0, 1'b0);
        checks++; if (bus.err !== 5'b00100) begin errors++; $display("FAIL trcd_short: got %b expected 00100", bus.err); end

        // tRP violated, then exactly met
        do_reset();
        issue(CMD_ACTIVE, 2'd1, 13'd2, 32'd0, 1'b0);
        nop(2);
        issue(CMD_PRECHARGE, 2'd1, 13'd0, 32'd0, 1'b0);
        issue(CMD_ACTIVE, 2'd1, 13'd2, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b00100) begin errors++; $display("FAIL trp_short: got %b expected 00100", bus.err); end
        do_reset();
        issue(CMD_ACTIVE, 2'd1, 13'd2, 32'd0, 1'b0);
        nop(2);
        issue(CMD_PRECHARGE, 2'd1, 13'd0, 32'd0, 1'b0);
        nop(2);
        issue(CMD_ACTIVE, 2'd1, 13'd2, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b00000) begin errors++; $display("FAIL trp_exact: got %b expected 00000", bus.err); end
    endtask

    task automatic test_refresh();
        do_reset();
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 32'd0, 1'b0);
        issue(CMD_REFRESH, 2'd0, 13'd0, 32'd0, 1'b0);
        checks++; if (bus.ref_count !== 16'd1 || bus.err !== 5'd0) begin errors++; $display("FAIL refresh_count: got cnt=%0d err=%b expected cnt=1 err=00000", bus.ref_count, bus.err); end
        nop(3);
        issue(CMD_ACTIVE, 2'd0, 13'd5, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b00100 || bus.ref_count !== 16'd1) begin errors++; $display("FAIL trfc_short: got err=%b cnt=%0d expected err=00100 cnt=1", bus.err, bus.ref_count); end

        do_reset();
        issue(CMD_REFRESH, 2'd0, 13'd0, 32'd0, 1'b0);
        nop(6);
        issue(CMD_ACTIVE, 2'd0, 13'd5, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b00000) begin errors++; $display("FAIL trfc_exact: got %b expected 00000", bus.err); end
        issue(CMD_REFRESH, 2'd0, 13'd0, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b01000 || bus.ref_count !== 16'd2) begin errors++; $display("FAIL refresh_busy: got err=%b cnt=%0d expected err=01000 cnt=2", bus.err, bus.ref_count); end
        nop(6);
        // all-bank precharge addressed to bank 1 must also close bank 0
        issue(CMD_PRECHARGE, 2'd1, 13'h400, 32'd0, 1'b0);
        nop(2);
        issue(CMD_ACTIVE, 2'd0, 13'd5, 32'd0, 1'b0);
        checks++; if (bus.err !== 5'b01000) begin errors++; $display("FAIL precharge_all: got %b expected 01000", bus.err); end
    endtask

    task automatic test_refi();
        do_reset();
        nop(1000);
        checks++; if (bus.err !== 5'b00000) begin errors++; $display("FAIL refi_edge: got %b expected 00000", bus.err); end
        nop(1);
        checks++; if (bus.err !== 5'b10000) begin errors++; $display("FAIL refi_over: got %b expected 10000", bus.err); end
        do_reset();
        nop(600);
        issue(CMD_REFRESH, 2'd0, 13'd0, 32'd0, 1'b0);
        nop(600);
        checks++; if (bus.err !== 5'b00000 || bus.ref_count !== 16'd1) begin errors++; $display("FAIL refi_rearm: got err=%b cnt=%0d expected err=00000 cnt=1", bus.err, bus.ref_count); end
    endtask

    task automatic test_mask_terminate();
        int unsigned seen;
        do_reset();
        issue(CMD_ACTIVE, 2'd2, 13'd1, 32'd0, 1'b0);
        nop(2);
        issue(CMD_WRITE, 2'd2, 13'h00C, 32'h11111111, 1'b0);
        bus.cle = 1'b0;
        issue(CMD_WRITE, 2'd2, 13'h00C, 32'h33333333, 1'b0);
        bus.cle = 1'b1;
        issue(CMD_WRITE, 2'd2, 13'h00C, 32'h22222222, 1'b1);
        issue(CMD_READ, 2'd2, 13'h00C, 32'd0, 1'b0);
        nop(2);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'h11111111) begin errors++; $display("FAIL mask_data: got v=%b d=%h expected v=1 d=11111111", bus.rd_valid, bus.dq_out); end
        checks++; if (bus.err !== 5'd0) begin errors++; $display("FAIL mask_err: got %b expected 00000", bus.err); end

        issue(CMD_READ, 2'd2, 13'h00C, 32'd0, 1'b0);
        issue(CMD_TERMINATE, 2'd0, 13'd0, 32'd0, 1'b0);
        seen = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.rd_valid === 1'b1) seen++;
            nop(1);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL terminate: got %0d rd_valid cycles expected 0", seen); end
        checks++; if (bus.dq_out !== 32'h11111111 || bus.err !== 5'd0) begin errors++; $display("FAIL terminate_hold: got d=%h err=%b expected d=11111111 err=00000", bus.dq_out, bus.err); end
    endtask

    task automatic test_reset_mid_read();
        int unsigned seen;
        do_reset();
        issue(CMD_REFRESH, 2'd0, 13'd0, 32'd0, 1'b0);
        nop(6);
        issue(CMD_ACTIVE, 2'd2, 13'd1, 32'd0, 1'b0);
        nop(2);
        issue(CMD_READ, 2'd2, 13'h00C, 32'd0, 1'b0);
        nop(2);
        checks++; if (bus.rd_valid !== 1'b1 || bus.dq_out !== 32'h11111111) begin errors++; $display("FAIL pre_reset_read: got v=%b d=%h expected v=1 d=11111111", bus.rd_valid, bus.dq_out); end
        issue(CMD_WRITE, 2'd0, 13'h000, 32'h0, 1'b0);
        checks++; if (bus.err !== 5'b00010 || bus.ref_count !== 16'd1) begin errors++; $display("FAIL pre_reset_state: got err=%b cnt=%0d expected err=00010 cnt=1", bus.err, bus.ref_count); end
        issue(CMD_READ, 2'd2, 13'h00C, 32'd0, 1'b0);
        rst = 1'b1;
        nop(1);
        checks++; if (bus.rd_valid !== 1'b0 || bus.dq_out !== 32'd0 || bus.err !== 5'd0 || bus.ref_count !== 16'd0) begin
            errors++; $display("FAIL mid_read_reset: got v=%b d=%h err=%b cnt=%0d expected all zero", bus.rd_valid, bus.dq_out, bus.err, bus.ref_count);
        end
        nop(1);
        rst = 1'b0;
        seen = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.rd_valid === 1'b1) seen++;
            nop(1);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_read_flush: got %0d rd_valid cycles expected 0", seen); end
    endtask

    initial begin
        set_nop();
        test_reset();
        test_basic_rw();
        test_back_to_back();
        test_protocol_errors();
        test_refresh();
        test_refi();
        test_mask_terminate();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
